regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised multi-read-port integer register file for the RV32I core with
//  per-register pending-write scoreboard, write-to-read bypass and a soft clear
//  sequencer. Sits between decode (reads, dest allocation) and writeback. Replaces
//  fixed 32x32 negedge-write file; writes now on posedge with same-cycle bypass.
// PARAMETERS
//  XLEN      32  data width per register
//  NREGS     32  number of registers (power of 2, >=2); AW = $clog2(NREGS) localparam
//  NRD       2   number of read ports
//  ZERO_REG  1   1: register 0 hardwired to zero, writes/allocs to it dropped
//  BYPASS    1   1: write data forwarded combinationally to matching read port
// PORTS
//  clk          in   1         clock, all state updates on rising edge
//  rst          in   1         asynchronous, active-low reset
//  rd_addr      in   NRD*AW    read addresses, port p = [p*AW +: AW]
//  rd_data      out  NRD*XLEN  read data, port p = [p*XLEN +: XLEN]
//  rd_busy      out  NRD       1 = register on port p has a pending write
//  wr_valid     in   1         writeback request
//  wr_ready     out  1         write accepted when wr_valid & wr_ready
//  wr_addr      in   AW        write address
//  wr_data      in   XLEN      write data
//  alloc_valid  in   1         decode marks destination pending
//  alloc_ready  out  1         alloc accepted when alloc_valid & alloc_ready
//  alloc_addr   in   AW        destination register to mark busy
//  clr_req      in   1         pulse: start soft clear of all registers
//  clr_busy     out  1         1 while clear sequence running
//  dbg_addr     in   AW        debug read address
//  dbg_data     out  XLEN      debug read data (no bypass, no zero override beyond ZERO_REG)
// BEHAVIOUR
//  - Reset (rst=0, async): all registers = 0, all busy bits = 0, FSM = IDLE, clear
//    index = 0; outputs: wr_ready=1 and alloc_ready=1 after release, clr_busy=0.
//  - Reads combinational, 0-cycle latency. ZERO_REG & addr==0 -> data 0, busy 0.
//  - wr_fire = wr_valid & wr_ready: reg[wr_addr] <= wr_data, busy[wr_addr] <= 0.
//  - alloc_fire = alloc_valid & alloc_ready: busy[alloc_addr] <= 1.
//  - Same cycle wr_fire and alloc_fire, same address: data written, busy ends 1.
//  - BYPASS=1, wr_fire & wr_addr==rd_addr[p] (non-zero reg): rd_data[p] = wr_data,
//    rd_busy[p] = 0. BYPASS=0: old data and registered busy until next edge.
//  - Write to register not marked busy is legal; busy stays 0.
//  - FSM IDLE: wr_ready=1, alloc_ready=1. clr_req -> CLEAR, idx=0, clr_busy=1.
//  - FSM CLEAR: each cycle reg[idx]<=0, busy[idx]<=0, idx++; wr_ready=0, alloc_ready=0;
//    clr_req ignored. After idx==NREGS-1 cleared -> IDLE. Exactly NREGS cycles;
//    clr_busy falls the edge after the last entry is cleared. idx wraps to 0.
//  - Reads during CLEAR return current (partially cleared) contents.
//  - Async reset mid-CLEAR aborts sequence; everything zero, IDLE.
// STRUCTURE
//  - Shared package rv32i_pkg: XLEN default, typedef regfile_state_e {RF_IDLE,
//    RF_CLEAR}, reg address width constant for the 32-entry default.
//  - One sub-module: regfile_clear_fsm (state, idx counter, clr_busy, ready gating).
//  - Storage, busy vector, read/bypass muxes in generate loops over NRD.
// TESTING
//  1 Reset: rst=0 mid-run -> all rd_data=0, rd_busy=0, clr_busy=0 asynchronously.
//  2 Write x5=0xDEADBEEF, read ports 0/1 at 5 same cycle -> 0xDEADBEEF (bypass), next cycle same.
//  3 Write x0=0x1234, alloc x0 -> rd_data x0 = 0, rd_busy 0.
//  4 Alloc x7 -> rd_busy=1 next cycle; write x7=0x55 -> busy 0 same cycle (bypass), 0 after.
//  5 Alloc and write x9 same cycle -> data 0xAA stored, busy=1 afterwards.
//  6 clr_req with x1..x31 loaded -> clr_busy 32 cycles, wr_ready=0 throughout, wr_valid
//    ignored, all zero after; reset asserted at idx=10 -> IDLE, all zero.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: data width, register-file address width and
// the register-file clear sequencer state encoding.
package rv32i_pkg;

  localparam int XLEN     = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = $clog2(RF_NREGS);

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } regfile_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Soft-clear sequencer: walks one register per cycle for NREGS cycles after clr_req.
// While running, it holds wr_ready/alloc_ready low so no new writes or allocations land.
module regfile_clear_fsm
  import rv32i_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic [AW-1:0] clr_idx,
  output logic          wr_ready,
  output logic          alloc_ready
);

  regfile_state_e state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    clr_busy    = 1'b0;
    wr_ready    = 1'b1;
    alloc_ready = 1'b1;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
      RF_CLEAR: begin
        clr_busy    = 1'b1;
        wr_ready    = 1'b0;
        alloc_ready = 1'b0;
        // NREGS is a power of two, so the increment wraps idx back to 0
        idx_d       = idx_q + 1'b1;
        if (idx_q == AW'(NREGS - 1)) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with pending-write busy bits, write-to-read bypass and soft clear.
// Reads are combinational (0 cycles); writes/allocs land on the rising edge and stall during clear.
module regfile_scoreboard
  import rv32i_pkg::*;
#(
  parameter int XLEN     = rv32i_pkg::XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                clr_req,
  output logic                clr_busy,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW-1:0]    clr_idx;
  logic             wr_fire, alloc_fire, wr_drop, alloc_drop;

  regfile_clear_fsm #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_fsm (
    .clk         (clk),
    .rst         (rst),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .clr_idx     (clr_idx),
    .wr_ready    (wr_ready),
    .alloc_ready (alloc_ready)
  );

  assign wr_fire    = wr_valid & wr_ready;
  assign alloc_fire = alloc_valid & alloc_ready;
  assign wr_drop    = (ZERO_REG != 0) && (wr_addr == '0);
  assign alloc_drop = (ZERO_REG != 0) && (alloc_addr == '0);

  // Alloc is applied after write so a same-cycle alloc of the same register leaves it busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      if (clr_busy) begin
        regs[clr_idx] <= '0;
        busy[clr_idx] <= 1'b0;
      end
      if (wr_fire && !wr_drop) begin
        regs[wr_addr] <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      if (alloc_fire && !alloc_drop) busy[alloc_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero, hit;
    assign addr    = rd_addr[p*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit     = (BYPASS != 0) && wr_fire && (wr_addr == addr);
    assign rd_data[p*XLEN +: XLEN] = is_zero ? '0 : (hit ? wr_data : regs[addr]);
    assign rd_busy[p] = !is_zero && !hit && busy[addr];
  end

  assign dbg_data = regs[dbg_addr];

endmodule
